alu_cmd_issuer: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_cmd_fifo.sv | 41 ++++
 rtl/alu_cmd_issuer.sv | 125 ++++++++++++
 tb/tb_alu_cmd_issuer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, issuer FSM states and the opcode legality check shared by the ALU issuer files
package alu_pkg;
   localparam int OP_ADD        = 0;
   localparam int OP_SUB        = 1;
   localparam int OP_OR         = 2;
   localparam int OP_AND        = 3;
   localparam int OP_SHL        = 4;
   localparam int OP_SHR        = 5;
   localparam int OP_LAST_LEGAL = 5;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   // Anything above the last decoded opcode would be aliased to ADD by the ALU decoder
   function automatic logic is_legal_op(input logic [31:0] op);
      return op <= 32'(OP_LAST_LEGAL);
   endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO holding {op, a, b} commands
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push, din  write request and data (ignored when full)
//   pop, dout  read request (ignored when empty) and head-of-queue data
//   full/empty occupancy flags
module alu_cmd_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   // Pointers carry one extra wrap bit to tell full from empty
   logic [AW:0] wp, rp;
   logic do_push, do_pop;
   assign empty   = wp == rp;
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rp[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + (AW+1)'(1);
         if (do_pop) rp <= rp + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= din;
   end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands, issues legal ones in order, returns results over a response stream
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid/ready, cmd_op/a/b     command stream in
//   alu_optcode/a/b, alu_valid      registered drive to the ALU datapath
//   alu_result                      ALU result, valid ALU_LATENCY edges after operands
//   rsp_valid/ready, rsp_result/op/illegal  response stream out
//   stat_issued, stat_illegal       saturating counters, only with ALU_ISSUE_STATS_EN defined
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int OP_WIDTH    = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int ALU_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [OP_WIDTH-1:0]   cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_a,
   input  logic [DATA_WIDTH-1:0] cmd_b,
   output logic [OP_WIDTH-1:0]   alu_optcode,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic                  alu_valid,
   input  logic [DATA_WIDTH-1:0] alu_result,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic [OP_WIDTH-1:0]   rsp_op,
   output logic                  rsp_illegal
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [15:0]           stat_issued,
   output logic [15:0]           stat_illegal
`endif
);
   localparam int CW = ALU_LATENCY > 0 ? $clog2(ALU_LATENCY + 1) : 1;
   localparam int FW = OP_WIDTH + 2 * DATA_WIDTH;
   logic [FW-1:0]         head;
   logic [OP_WIDTH-1:0]   h_op;
   logic [DATA_WIDTH-1:0] h_a, h_b;
   logic                  full, empty, pop, legal;
   logic [CW-1:0]         cnt;
   state_t                state;
   assign {h_op, h_a, h_b} = head;
   assign cmd_ready = !full;
   assign pop       = (state == IDLE) && !empty;
   assign legal     = is_legal_op(32'(h_op));
   alu_cmd_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (cmd_valid && cmd_ready),
      .din  ({cmd_op, cmd_a, cmd_b}),
      .pop  (pop),
      .dout (head),
      .full (full),
      .empty(empty)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         alu_optcode <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_valid   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_result  <= '0;
         rsp_op      <= '0;
         rsp_illegal <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop && legal) begin
                  alu_optcode <= h_op;
                  alu_a       <= h_a;
                  alu_b       <= h_b;
                  alu_valid   <= 1'b1;
                  cnt         <= CW'(ALU_LATENCY);
                  state       <= WAIT;
               end else if (pop) begin
                  // Illegal ops bypass the ALU; its operand registers stay quiet
                  rsp_result  <= '0;
                  rsp_illegal <= 1'b1;
                  rsp_op      <= h_op;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  rsp_result  <= alu_result;
                  rsp_op      <= alu_optcode;
                  rsp_illegal <= 1'b0;
                  rsp_valid   <= 1'b1;
                  alu_valid   <= 1'b0;
                  state       <= RESP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef ALU_ISSUE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued  <= '0;
         stat_illegal <= '0;
      end else begin
         if (pop && legal && stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
         if (pop && !legal && stat_illegal != 16'hFFFF) stat_illegal <= stat_illegal + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed and random checks of alu_cmd_issuer against a response-queue reference model
module tb_alu_cmd_issuer;
   import alu_pkg::*;
   logic       clk, rst;
   logic       cmd_valid, cmd_ready;
   logic [3:0] cmd_op;
   logic [7:0] cmd_a, cmd_b;
   logic [3:0] alu_optcode;
   logic [7:0] alu_a, alu_b;
   logic       alu_valid;
   logic [7:0] alu_result;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_result;
   logic [3:0] rsp_op;
   logic       rsp_illegal;
   int n_assert = 0;
   int n_fail = 0;
   int n_rsp = 0;
   typedef struct {
      logic [3:0] op;
      logic [7:0] res;
      logic       ill;
   } rsp_t;
   rsp_t exp_q[$];
   alu_cmd_issuer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_optcode(alu_optcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_valid(alu_valid), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_illegal(rsp_illegal)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (32'(op))
         OP_SUB:  return a - b;
         OP_OR:   return a | b;
         OP_AND:  return a & b;
         OP_SHL:  return a << b;
         OP_SHR:  return a >> b;
         default: return a + b;
      endcase
   endfunction
   // External ALU with one edge of latency
   always @(posedge clk) alu_result <= alu_f(alu_optcode, alu_a, alu_b);
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // Called at a negedge: account for handshakes that the coming posedge completes, then move to the next negedge
   task automatic tick();
      rsp_t e;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (cmd_valid && cmd_ready) begin
            e.op  = cmd_op;
            e.ill = cmd_op > 4'd5;
            e.res = e.ill ? 8'h00 : alu_f(cmd_op, cmd_a, cmd_b);
            exp_q.push_back(e);
         end
         if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("rsp_result", rsp_result, e.res);
               chk("rsp_op", rsp_op, e.op);
               chk("rsp_illegal", rsp_illegal, e.ill);
               n_rsp++;
            end
         end
      end
      @(negedge clk);
   endtask
   task automatic offer(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      cmd_op = op;
      cmd_a = a;
      cmd_b = b;
      cmd_valid = 1'b1;
   endtask
   task automatic send_wait(output bit ok);
      int t = 0;
      while (!cmd_ready && t < 16) begin
         tick();
         t++;
      end
      ok = cmd_ready;
      if (ok) begin
         tick();
         cmd_valid = 1'b0;
      end
   endtask
   task automatic drain(input int bound);
      int t = 0;
      bit a;
      while ((exp_q.size() != 0 || cmd_valid) && t < bound) begin
         a = cmd_valid && cmd_ready;
         tick();
         if (a) cmd_valid = 1'b0;
         t++;
      end
      chk("drain_done", 32'(exp_q.size()), 0);
   endtask
   initial begin
      int k, na, acc, base, sent, t;
      bit ok, a;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = '0;
      cmd_a = '0;
      cmd_b = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      tick();
      tick();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_valid", alu_valid, 0);
      chk("rst_alu_optcode", alu_optcode, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_illegal", rsp_illegal, 0);
      rst = 1'b0;
      tick();
      // ADD 5+3
      rsp_ready = 1'b1;
      offer(4'd0, 8'h05, 8'h03);
      tick();
      cmd_valid = 1'b0;
      k = 0;
      na = 0;
      while (!rsp_valid && k < 12) begin
         na += int'(alu_valid);
         tick();
         k++;
      end
      chk("add_latency", k, 3);
      chk("add_alu_valid_cycles", na, 2);
      chk("add_rsp_result", rsp_result, 8'h08);
      chk("add_rsp_op", rsp_op, 0);
      chk("add_rsp_illegal", rsp_illegal, 0);
      chk("add_alu_valid_done", alu_valid, 0);
      tick();
      chk("add_rsp_consumed", rsp_valid, 0);
      // Illegal opcode 9
      offer(4'd9, 8'hFF, 8'h12);
      tick();
      cmd_valid = 1'b0;
      k = 0;
      na = 0;
      while (!rsp_valid && k < 12) begin
         na += int'(alu_valid);
         tick();
         k++;
      end
      na += int'(alu_valid);
      chk("ill_latency", k, 1);
      chk("ill_alu_valid_cycles", na, 0);
      chk("ill_rsp_illegal", rsp_illegal, 1);
      chk("ill_rsp_result", rsp_result, 0);
      chk("ill_rsp_op", rsp_op, 9);
      chk("ill_alu_optcode_held", alu_optcode, 0);
      chk("ill_alu_a_held", alu_a, 8'h05);
      chk("ill_alu_b_held", alu_b, 8'h03);
      tick();
      // Backpressure: six commands offered with responses stalled
      rsp_ready = 1'b0;
      acc = 0;
      base = n_rsp;
      for (int i = 0; i < 6; i++) begin
         offer(4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
         send_wait(ok);
         if (ok) acc++;
      end
      chk("bp_accepted", acc, 5);
      chk("bp_cmd_ready_low", cmd_ready, 0);
      rsp_ready = 1'b1;
      drain(200);
      chk("bp_responses", n_rsp - base, 6);
      // Full FIFO with simultaneous pop: SHL 0x81 by 1 sits at the head
      rsp_ready = 1'b0;
      offer(4'd0, 8'($urandom), 8'($urandom));
      send_wait(ok);
      offer(4'd4, 8'h81, 8'h01);
      send_wait(ok);
      for (int i = 0; i < 3; i++) begin
         offer(4'($urandom_range(0, 5)), 8'($urandom), 8'($urandom));
         send_wait(ok);
      end
      offer(4'd2, 8'($urandom), 8'($urandom));
      t = 0;
      while (!rsp_valid && t < 10) begin
         tick();
         t++;
      end
      chk("fp_stalled_rsp", rsp_valid, 1);
      chk("fp_full", cmd_ready, 0);
      rsp_ready = 1'b1;
      t = 0;
      while (!cmd_ready && t < 10) begin
         tick();
         t++;
      end
      chk("fp_ready_delay", t, 2);
      chk("fp_issued_op", alu_optcode, 4);
      chk("fp_issued_a", alu_a, 8'h81);
      chk("fp_issued_b", alu_b, 8'h01);
      base = n_rsp;
      drain(200);
      chk("fp_responses", n_rsp - base, 5);
      // Reset while an op waits on the ALU with two commands queued
      for (int i = 0; i < 3; i++) begin
         offer(4'($urandom_range(0, 5)), 8'($urandom), 8'($urandom));
         send_wait(ok);
      end
      chk("rw_in_flight", alu_valid, 1);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rw_rsp_valid", rsp_valid, 0);
      chk("rw_cmd_ready", cmd_ready, 1);
      chk("rw_alu_valid", alu_valid, 0);
      na = 0;
      for (int i = 0; i < 10; i++) begin
         na += int'(rsp_valid) + int'(alu_valid);
         tick();
      end
      chk("rw_quiet", na, 0);
      // Random traffic
      sent = 0;
      t = 0;
      while ((sent < 40 || exp_q.size() != 0 || rsp_valid) && t < 3000) begin
         if (!cmd_valid && sent < 40 && $urandom_range(0, 1) == 1)
            offer(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
         rsp_ready = 1'($urandom);
         a = cmd_valid && cmd_ready;
         tick();
         if (a) begin
            cmd_valid = 1'b0;
            sent++;
         end
         t++;
      end
      chk("rand_sent", sent, 40);
      chk("rand_drained", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
